// File: rtl/mc_controller_if.sv
// Control bundle between the multi-cycle controller and its datapath/memory.
// The controller is the master: it consumes the held opcode, stall and
// memory-ready, and drives every enable plus its status flags.
interface mc_controller_if;
  logic [6:0] opcode;
  logic       stall;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_we;
  logic       ir_we;
  logic       pc_we;
  logic       reg_we;
  logic       memtoreg;
  logic       alu_src;
  logic [1:0] aluop;
  logic       branch;
  logic       jump;
  logic       retire;
  logic       illegal;
  logic       timeout;
  logic [2:0] state;

  modport master (
    input  opcode, stall, mem_ready,
    output mem_req, mem_we, ir_we, pc_we, reg_we, memtoreg, alu_src,
           aluop, branch, jump, retire, illegal, timeout, state
  );

  modport slave (
    output opcode, stall, mem_ready,
    input  mem_req, mem_we, ir_we, pc_we, reg_we, memtoreg, alu_src,
           aluop, branch, jump, retire, illegal, timeout, state
  );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle instruction controller: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// The opcode is captured in DECODE so later states ignore the live field.
// A per-access wait counter traps a memory that never answers.
module mc_controller #(
  parameter int MEM_TIMEOUT  = 16,
  parameter bit SUPPORT_JUMP = 1'b1
) (
  input logic            clk,
  input logic            rst,
  mc_controller_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [2:0] C_L    = 3'd0;
  localparam logic [2:0] C_S    = 3'd1;
  localparam logic [2:0] C_R    = 3'd2;
  localparam logic [2:0] C_B    = 3'd3;
  localparam logic [2:0] C_I    = 3'd4;
  localparam logic [2:0] C_JAL  = 3'd5;
  localparam logic [2:0] C_JALR = 3'd6;
  localparam logic [2:0] C_ILL  = 3'd7;

  // A zero timeout still needs a 1-bit counter to keep the declarations legal.
  localparam int             CW       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  TO_LIMIT = CW'(MEM_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [6:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ill_q, ill_d;
  logic          to_q, to_d;

  logic [2:0] cls_q;
  logic       wait_hit;

  logic       mem_req, mem_we, ir_we, pc_we, reg_we, memtoreg, alu_src;
  logic [1:0] aluop;
  logic       branch, jump, retire, illegal, timeout;
  logic [2:0] state;

  function automatic logic [2:0] classify(input logic [6:0] op);
    case (op)
      7'b0000011: classify = C_L;
      7'b0100011: classify = C_S;
      7'b0110011: classify = C_R;
      7'b1100011: classify = C_B;
      7'b0010011: classify = C_I;
      7'b1101111: classify = SUPPORT_JUMP ? C_JAL  : C_ILL;
      7'b1100111: classify = SUPPORT_JUMP ? C_JALR : C_ILL;
      default:    classify = C_ILL;
    endcase
  endfunction

  assign cls_q    = classify(op_q);
  assign wait_hit = (MEM_TIMEOUT > 0) && (cnt_q == TO_LIMIT) && !bus.mem_ready;

  // Next-state, counter and output decode for the current state.
  always_comb begin
    // NOTE: every combinational output and next-state gets a default here so
    // no path through the case statements can infer a latch.
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    reg_we   = 1'b0;
    memtoreg = 1'b0;
    alu_src  = 1'b0;
    aluop    = 2'b00;
    branch   = 1'b0;
    jump     = 1'b0;
    retire   = 1'b0;
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    to_d     = to_q;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_hit) begin
          state_d = S_TRAP;
          to_d    = 1'b1;
        end
      end
      S_DECODE: begin
        op_d    = bus.opcode;
        state_d = (classify(bus.opcode) == C_ILL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        case (cls_q)
          C_L, C_S: begin alu_src = 1'b1; state_d = S_MEM; end
          C_I:      begin alu_src = 1'b1; state_d = S_WB;  end
          C_R:      begin aluop = 2'b10;  state_d = S_WB;  end
          C_B: begin
            aluop   = 2'b01;
            branch  = 1'b1;
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          C_JAL:  begin jump = 1'b1; pc_we = 1'b1; state_d = S_WB; end
          C_JALR: begin jump = 1'b1; pc_we = 1'b1; alu_src = 1'b1; state_d = S_WB; end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == C_S);
        if (bus.mem_ready) begin
          if (cls_q == C_S) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_hit) begin
          state_d = S_TRAP;
          to_d    = 1'b1;
        end
      end
      S_WB: begin
        reg_we   = 1'b1;
        memtoreg = (cls_q == C_L);
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: ;
      default: state_d = S_TRAP;
    endcase

    // Stall freezes all state and kills every strobe; datapath selects stay.
    if (bus.stall) begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      reg_we  = 1'b0;
      branch  = 1'b0;
      jump    = 1'b0;
      retire  = 1'b0;
    end else if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready) begin
      cnt_d = cnt_q + CW'(1);
    end

    ill_d = ill_q | (state_d == S_TRAP);

    state   = state_q;
    illegal = ill_q;
    timeout = to_q;

    // Outputs are quiet for the whole reset cycle, whatever state was held.
    if (rst) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      reg_we   = 1'b0;
      memtoreg = 1'b0;
      alu_src  = 1'b0;
      aluop    = 2'b00;
      branch   = 1'b0;
      jump     = 1'b0;
      retire   = 1'b0;
      state    = S_FETCH;
      illegal  = 1'b0;
      timeout  = 1'b0;
    end
  end

  // State, opcode latch, wait counter and sticky flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
    end
  end

  assign bus.mem_req  = mem_req;
  assign bus.mem_we   = mem_we;
  assign bus.ir_we    = ir_we;
  assign bus.pc_we    = pc_we;
  assign bus.reg_we   = reg_we;
  assign bus.memtoreg = memtoreg;
  assign bus.alu_src  = alu_src;
  assign bus.aluop    = aluop;
  assign bus.branch   = branch;
  assign bus.jump     = jump;
  assign bus.retire   = retire;
  assign bus.illegal  = illegal;
  assign bus.timeout  = timeout;
  assign bus.state    = state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller. Two instances share clock, reset and
// inputs: A uses the default parameters, B uses MEM_TIMEOUT=4 with jumps
// disabled. Each cycle pushes the expected output word to a scoreboard queue
// and pops it when the selected instance's outputs are sampled.
module tb_mc_controller;

  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  // Flag bits below the 3-bit state in the packed output word.
  localparam logic [13:0] NONE  = 14'h0000;
  localparam logic [13:0] MREQ  = 14'h2000;
  localparam logic [13:0] MWE   = 14'h1000;
  localparam logic [13:0] IRWE  = 14'h0800;
  localparam logic [13:0] PCWE  = 14'h0400;
  localparam logic [13:0] REGWE = 14'h0200;
  localparam logic [13:0] M2R   = 14'h0100;
  localparam logic [13:0] ASRC  = 14'h0080;
  localparam logic [13:0] AOP_R = 14'h0040;
  localparam logic [13:0] AOP_B = 14'h0020;
  localparam logic [13:0] BR    = 14'h0010;
  localparam logic [13:0] JMP   = 14'h0008;
  localparam logic [13:0] RET   = 14'h0004;
  localparam logic [13:0] ILL   = 14'h0002;
  localparam logic [13:0] TO    = 14'h0001;
  localparam logic [13:0] FETCHED = MREQ | IRWE | PCWE;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic       stall;
  logic       mem_ready;
  logic       sel;

  logic [16:0] obs_a, obs_b, obs;
  logic [16:0] sb[$];
  int checks;
  int failures;

  mc_controller_if ifa ();
  mc_controller_if ifb ();

  assign ifa.opcode    = opcode;
  assign ifa.stall     = stall;
  assign ifa.mem_ready = mem_ready;
  assign ifb.opcode    = opcode;
  assign ifb.stall     = stall;
  assign ifb.mem_ready = mem_ready;

  mc_controller dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  mc_controller #(.MEM_TIMEOUT(4), .SUPPORT_JUMP(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  assign obs_a = {ifa.state, ifa.mem_req, ifa.mem_we, ifa.ir_we, ifa.pc_we,
                  ifa.reg_we, ifa.memtoreg, ifa.alu_src, ifa.aluop,
                  ifa.branch, ifa.jump, ifa.retire, ifa.illegal, ifa.timeout};
  assign obs_b = {ifb.state, ifb.mem_req, ifb.mem_we, ifb.ir_we, ifb.pc_we,
                  ifb.reg_we, ifb.memtoreg, ifb.alu_src, ifb.aluop,
                  ifb.branch, ifb.jump, ifb.retire, ifb.illegal, ifb.timeout};
  assign obs   = sel ? obs_b : obs_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] e(input logic [2:0] st, input logic [13:0] f);
    e = {st, f};
  endfunction

  // One clock: drive inputs after the falling edge, queue the expectation,
  // then sample the combinational outputs before the next rising edge.
  task automatic cyc(input string tag, input logic r, input logic [6:0] op,
                     input logic s, input logic rd, input logic [16:0] ex);
    logic [16:0] want;
    @(negedge clk);
    rst       = r;
    opcode    = op;
    stall     = s;
    mem_ready = rd;
    sb.push_back(ex);
    #1;
    want = sb.pop_front();
    checks++;
    assert (obs === want)
      else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
      end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    sel       = 1'b0;
    rst       = 1'b1;
    opcode    = OP_R;
    stall     = 1'b0;
    mem_ready = 1'b0;

    // Reset: all outputs low, even with ready and stall active.
    cyc("rst_idle",  1'b1, OP_R, 1'b0, 1'b0, e(3'd0, NONE));
    cyc("rst_busy",  1'b1, OP_R, 1'b1, 1'b1, e(3'd0, NONE));

    // R-type, ready in the first fetch cycle.
    cyc("r_fetch",   1'b0, OP_R, 1'b0, 1'b1, e(3'd0, FETCHED));
    cyc("r_decode",  1'b0, OP_R, 1'b0, 1'b0, e(3'd1, NONE));
    cyc("r_exec",    1'b0, OP_R, 1'b0, 1'b0, e(3'd2, AOP_R));
    cyc("r_wb",      1'b0, OP_R, 1'b0, 1'b0, e(3'd4, REGWE | RET));

    // Load with three wait cycles in MEM.
    cyc("l_fetch",   1'b0, OP_L, 1'b0, 1'b1, e(3'd0, FETCHED));
    cyc("l_decode",  1'b0, OP_L, 1'b0, 1'b0, e(3'd1, NONE));
    cyc("l_exec",    1'b0, OP_L, 1'b0, 1'b0, e(3'd2, ASRC));
    for (int i = 0; i < 3; i++)
      cyc("l_mem_wait", 1'b0, OP_L, 1'b0, 1'b0, e(3'd3, MREQ));
    cyc("l_mem_done", 1'b0, OP_L, 1'b0, 1'b1, e(3'd3, MREQ));
    cyc("l_wb",       1'b0, OP_L, 1'b0, 1'b1, e(3'd4, REGWE | M2R | RET));

    // Store stalled for two cycles in MEM; ready during stall is ignored.
    cyc("s_fetch",   1'b0, OP_S, 1'b0, 1'b1, e(3'd0, FETCHED));
    cyc("s_decode",  1'b0, OP_S, 1'b0, 1'b0, e(3'd1, NONE));
    cyc("s_exec",    1'b0, OP_S, 1'b0, 1'b0, e(3'd2, ASRC));
    cyc("s_stall0",  1'b0, OP_S, 1'b1, 1'b1, e(3'd3, NONE));
    cyc("s_stall1",  1'b0, OP_S, 1'b1, 1'b1, e(3'd3, NONE));
    cyc("s_mem",     1'b0, OP_S, 1'b0, 1'b0, e(3'd3, MREQ | MWE));
    cyc("s_done",    1'b0, OP_S, 1'b0, 1'b1, e(3'd3, MREQ | MWE | RET));
    cyc("s_back",    1'b0, OP_S, 1'b0, 1'b0, e(3'd0, MREQ));

    // JAL with the opcode field changed to a store after decode.
    cyc("jal_fetch", 1'b0, OP_JAL, 1'b0, 1'b1, e(3'd0, FETCHED));
    cyc("jal_dec",   1'b0, OP_JAL, 1'b0, 1'b0, e(3'd1, NONE));
    cyc("jal_exec",  1'b0, OP_S,   1'b0, 1'b0, e(3'd2, JMP | PCWE));
    cyc("jal_wb",    1'b0, OP_S,   1'b0, 1'b0, e(3'd4, REGWE | RET));

    // JALR uses the immediate operand.
    cyc("jalr_fetch", 1'b0, OP_JALR, 1'b0, 1'b1, e(3'd0, FETCHED));
    cyc("jalr_dec",   1'b0, OP_JALR, 1'b0, 1'b0, e(3'd1, NONE));
    cyc("jalr_exec",  1'b0, OP_JALR, 1'b0, 1'b0, e(3'd2, JMP | PCWE | ASRC));
    cyc("jalr_wb",    1'b0, OP_JALR, 1'b0, 1'b0, e(3'd4, REGWE | RET));

    // Branch retires from EXEC.
    cyc("b_fetch",   1'b0, OP_B, 1'b0, 1'b1, e(3'd0, FETCHED));
    cyc("b_dec",     1'b0, OP_B, 1'b0, 1'b0, e(3'd1, NONE));
    cyc("b_exec",    1'b0, OP_B, 1'b0, 1'b0, e(3'd2, AOP_B | BR | PCWE | RET));
    cyc("b_back",    1'b0, OP_B, 1'b0, 1'b0, e(3'd0, MREQ));

    // Reset wins over stall in the middle of a load access.
    cyc("rm_fetch",  1'b0, OP_L, 1'b0, 1'b1, e(3'd0, FETCHED));
    cyc("rm_dec",    1'b0, OP_L, 1'b0, 1'b0, e(3'd1, NONE));
    cyc("rm_exec",   1'b0, OP_L, 1'b0, 1'b0, e(3'd2, ASRC));
    cyc("rm_mem",    1'b0, OP_L, 1'b0, 1'b0, e(3'd3, MREQ));
    cyc("rm_rst",    1'b1, OP_L, 1'b1, 1'b1, e(3'd0, NONE));
    cyc("rm_after",  1'b0, OP_L, 1'b0, 1'b0, e(3'd0, MREQ));

    // Illegal opcode traps and holds until reset.
    cyc("ill_fetch", 1'b0, OP_BAD, 1'b0, 1'b1, e(3'd0, FETCHED));
    cyc("ill_dec",   1'b0, OP_BAD, 1'b0, 1'b0, e(3'd1, NONE));
    for (int i = 0; i < 12; i++)
      cyc("ill_hold", 1'b0, (i % 2 == 0) ? OP_R : OP_BAD, i[0], 1'b1, e(3'd7, ILL));
    cyc("ill_rst",   1'b1, OP_R, 1'b0, 1'b0, e(3'd0, NONE));
    cyc("ill_clear", 1'b0, OP_R, 1'b0, 1'b0, e(3'd0, MREQ));

    // Instance B: jumps disabled, four-cycle memory timeout.
    sel = 1'b1;
    cyc("b_rst",      1'b1, OP_JAL, 1'b0, 1'b0, e(3'd0, NONE));
    cyc("nj_fetch",   1'b0, OP_JAL, 1'b0, 1'b1, e(3'd0, FETCHED));
    cyc("nj_dec",     1'b0, OP_JAL, 1'b0, 1'b0, e(3'd1, NONE));
    cyc("nj_trap0",   1'b0, OP_JAL, 1'b0, 1'b0, e(3'd7, ILL));
    cyc("nj_trap1",   1'b0, OP_R,   1'b0, 1'b1, e(3'd7, ILL));
    cyc("nj_rst",     1'b1, OP_R,   1'b0, 1'b0, e(3'd0, NONE));

    for (int i = 0; i < 4; i++)
      cyc("to_fetch", 1'b0, OP_R, 1'b0, 1'b0, e(3'd0, MREQ));
    cyc("to_trap0",   1'b0, OP_R, 1'b0, 1'b1, e(3'd7, ILL | TO));
    cyc("to_trap1",   1'b0, OP_R, 1'b0, 1'b0, e(3'd7, ILL | TO));
    cyc("to_rst",     1'b1, OP_R, 1'b0, 1'b0, e(3'd0, NONE));

    for (int i = 0; i < 3; i++)
      cyc("edge_wait", 1'b0, OP_R, 1'b0, 1'b0, e(3'd0, MREQ));
    cyc("edge_ready", 1'b0, OP_R, 1'b0, 1'b1, e(3'd0, FETCHED));
    cyc("edge_dec",   1'b0, OP_R, 1'b0, 1'b0, e(3'd1, NONE));
    cyc("edge_exec",  1'b0, OP_R, 1'b0, 1'b0, e(3'd2, AOP_R));
    cyc("edge_wb",    1'b0, OP_R, 1'b0, 1'b0, e(3'd4, REGWE | RET));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16, giving the number of cycles a memory request may wait for mem_ready before trapping; 0 disables the timeout.
REQ-002 The block SHALL have parameter SUPPORT_JUMP, default 1; when 0, JAL/JALR SHALL be decoded as illegal.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset; synchronous, active-high.
REQ-005 The block SHALL have the following inputs:
- opcode, 7 bits, opcode field of the held instruction register.
- stall, 1 bit, freeze request.
- mem_ready, 1 bit, memory completes the current request this cycle.
REQ-006 The block SHALL have the following outputs, each 1 bit unless stated:
- mem_req, memory access request.
- mem_we, store.
- ir_we, instruction register load.
- pc_we, PC update.
- reg_we, register file write.
- memtoreg, writeback source is memory.
- alu_src, ALU B operand is the immediate.
- aluop, 2 bits.
- branch, branch compare.
- jump, unconditional jump.
- retire, instruction complete.
- illegal, sticky trap flag.
- timeout, sticky trap cause.
- state, 3 bits, current state.

Function
REQ-007 The FSM SHALL have the state encodings FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7; codes 5 and 6 SHALL go to TRAP with illegal=1.
REQ-008 The FSM SHALL recognise these opcode classes:
- L 0000011
- S 0100011
- R 0110011
- B 1100011
- I 0010011
- JAL 1101111
- JALR 1100111
- every other value is illegal.
REQ-009 FETCH SHALL behave as follows:
- mem_req=1 throughout.
- On mem_ready=1, ir_we=1 and pc_we=1 in that same cycle, and the next state is DECODE.
- Otherwise the FSM stays in FETCH.
REQ-010 DECODE SHALL last exactly one cycle and register the opcode into an internal latch.
- Illegal opcode: next state is TRAP.
- Legal opcode: next state is EXEC.
REQ-011 All states after DECODE SHALL decode from the latched opcode only; changes on opcode after DECODE SHALL have no effect.
REQ-012 EXEC outputs SHALL depend on the latched class:
- L, S, I: alu_src=1, aluop=00.
- R: alu_src=0, aluop=10.
- B: alu_src=0, aluop=01, branch=1.
- JAL: jump=1, pc_we=1, alu_src=0.
- JALR: jump=1, pc_we=1, alu_src=1.
- B additionally asserts pc_we=1, gated externally by the comparison result.
REQ-013 EXEC next state SHALL be:
- L, S: MEM.
- R, I, JAL, JALR: WB.
- B: FETCH, with retire=1 in the EXEC cycle.
REQ-014 MEM SHALL behave as follows:
- mem_req=1 throughout; mem_we=1 for S only.
- On mem_ready=1, S goes to FETCH with retire=1, and L goes to WB.
- Otherwise the FSM stays in MEM.
REQ-015 WB SHALL last one cycle with reg_we=1, memtoreg=1 for L (0 otherwise), and retire=1; next state is FETCH.
REQ-016 In TRAP all enables SHALL be 0, illegal=1, and the FSM SHALL remain in TRAP until rst.
REQ-017 When stall=1, the following SHALL hold:
- The state register, opcode latch and timeout counter hold their values.
- mem_req, mem_we, ir_we, pc_we, reg_we, branch, jump and retire are forced to 0.
- mem_ready is ignored.
REQ-018 The timeout counter SHALL work as follows:
- Width $clog2(MEM_TIMEOUT+1).
- Cleared on every state transition.
- Increments on each non-stalled cycle in FETCH or MEM with mem_ready=0.
REQ-019 When the timeout counter equals MEM_TIMEOUT-1 and mem_ready=0 (MEM_TIMEOUT>0), the next state SHALL be TRAP and timeout SHALL be set.
REQ-020 mem_ready=1 in the same cycle that the timeout is reached SHALL complete the access normally; ready has priority.
REQ-021 All outputs not listed as asserted for a state SHALL be 0; aluop defaults to 00.
REQ-022 mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-023 rst=1 SHALL synchronously set:
- state=FETCH.
- Opcode latch = 0.
- Counter = 0.
- illegal=0, timeout=0.
REQ-024 rst SHALL take priority over stall and over every state, including TRAP and mid-access in MEM.
REQ-025 During the rst cycle all outputs SHALL be 0; mem_req becomes 1 in the first cycle after rst deasserts.

Verification
REQ-026 The bench SHALL cover an R-type instruction with 0110011 and mem_ready=1 in the first FETCH cycle:
- state sequence 0,1,2,4,0.
- aluop=10 in EXEC.
- reg_we=1 and retire=1 in WB; total 4 cycles.
REQ-027 The bench SHALL cover a load with 0000011 and mem_ready delayed 3 cycles in MEM:
- MEM held for 4 cycles with mem_req=1 and mem_we=0.
- Then WB with memtoreg=1 and reg_we=1.
REQ-028 The bench SHALL cover a store 0100011 with stall=1 held for 2 cycles during MEM:
- state stays 3 and mem_req=0 while stalled.
- After release, mem_we=1 and mem_ready completes to FETCH with retire=1, and reg_we is never 1.
REQ-029 The bench SHALL cover the illegal paths:
- Opcode 1111111 gives DECODE then TRAP, with illegal=1 and state=7 held for 10+ cycles.
- rst=1 for one cycle returns state=0 with illegal=0.
- With SUPPORT_JUMP=0, opcode 1101111 also traps.
REQ-030 The bench SHALL cover the timeout with MEM_TIMEOUT=4 and mem_ready stuck at 0 in FETCH:
- TRAP is entered after exactly 4 FETCH cycles, with timeout=1.
- A repeat with mem_ready=1 on the 4th cycle completes the fetch normally.
REQ-031 The bench SHALL cover JAL 1101111 (SUPPORT_JUMP=1):
- jump=1 and pc_we=1 in EXEC.
- reg_we=1 and memtoreg=0 in WB.
- Opcode toggled to 0100011 during EXEC does not change the behaviour.
